// File: rtl/lapido_pkg.sv
// Shared forwarding types: mux select encodings and the pipeline tracking entry.
// FWD_MEM_WB_EN (optional) enables MEM/WB forwarding in fwd_compare.
package lapido_pkg;

  // Entries carry a fixed-width rd; narrower register addresses are zero-extended.
  localparam int ENTRY_RD_W = 8;
  typedef logic [ENTRY_RD_W-1:0] entry_rd_t;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'd0,
    FWD_EXMEM   = 2'd1,
    FWD_MEMWB   = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic      valid;
    entry_rd_t rd;
    logic      reg_write;
    logic      mem_read;
  } track_entry_t;

  localparam track_entry_t BUBBLE = '0;

  function automatic logic entry_writes(track_entry_t e, entry_rd_t src);
    return e.valid && e.reg_write && (e.rd == src) && (src != '0);
  endfunction

endpackage

// File: rtl/forward_ctrl_compare.sv
// fwd_compare: maps one source register against ex_e/mem_e to a mux select and a stall hit.
// FWD_MEM_WB_EN defined: mem_e matches forward (select 2); undefined: they stall instead.
module fwd_compare
  import lapido_pkg::*;
(
  input  logic [ENTRY_RD_W-1:0] src,
  input  track_entry_t          ex_e,
  input  track_entry_t          mem_e,
  output logic [1:0]            sel,
  output logic                  hit
);

  logic ex_match;
  logic mem_match;
  logic unused_mem_read;

  assign ex_match        = entry_writes(ex_e, src);
  assign mem_match       = entry_writes(mem_e, src);
  assign unused_mem_read = mem_e.mem_read;

  // The youngest producer wins; a load in EX cannot forward yet, so it raises hit.
  always_comb begin
    sel = FWD_REGFILE;
    hit = 1'b0;
    if (ex_match) begin
      sel = FWD_EXMEM;
      hit = ex_e.mem_read;
    end else if (mem_match) begin
`ifdef FWD_MEM_WB_EN
      sel = FWD_MEMWB;
`else
      hit = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/forward_ctrl.sv
// forward_ctrl: tracks EX/MEM/WB destinations and produces registered forwarding selects and a load-use stall.
// Optional macro FWD_MEM_WB_EN enables MEM/WB forwarding (otherwise a MEM-stage match stalls one cycle).
module forward_ctrl
  import lapido_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  stall
);

  track_entry_t ex_e;
  track_entry_t mem_e;
  track_entry_t wb_e;
  track_entry_t id_e;
  logic [1:0]   sel_a;
  logic [1:0]   sel_b;
  logic         hit_a;
  logic         hit_b;
  logic         hold;
  logic         unused_wb;

  assign id_e = '{valid:     1'b1,
                  rd:        entry_rd_t'(id_rd),
                  reg_write: id_reg_write,
                  mem_read:  id_mem_read};

  fwd_compare u_cmp_a (
    .src   (entry_rd_t'(id_rs)),
    .ex_e  (ex_e),
    .mem_e (mem_e),
    .sel   (sel_a),
    .hit   (hit_a)
  );

  fwd_compare u_cmp_b (
    .src   (entry_rd_t'(id_rt)),
    .ex_e  (ex_e),
    .mem_e (mem_e),
    .sel   (sel_b),
    .hit   (hit_b)
  );

  // Flush outranks a load-use hit; reset masks stall before the state has cleared.
  assign stall = (hit_a | hit_b) & ~flush & ~rst;
  assign hold  = stall | flush;

  // wb_e marks the retiring instruction; the register file covers it, so nothing reads it.
  assign unused_wb = ^wb_e;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_e      <= BUBBLE;
      mem_e     <= BUBBLE;
      wb_e      <= BUBBLE;
      fwd_sel_a <= FWD_REGFILE;
      fwd_sel_b <= FWD_REGFILE;
    end else begin
      ex_e      <= hold ? BUBBLE : id_e;
      mem_e     <= ex_e;
      wb_e      <= mem_e;
      fwd_sel_a <= hold ? FWD_REGFILE : sel_a;
      fwd_sel_b <= hold ? FWD_REGFILE : sel_b;
    end
  end

endmodule

// File: tb/tb_forward_ctrl.sv
// Self-checking bench for forward_ctrl: directed hazard scenarios plus random traffic,
// checked against a model that tracks the two most recent issued instructions by age.
module tb_forward_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       flush;
  logic [1:0] fwd_sel_a;
  logic [1:0] fwd_sel_b;
  logic       stall;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit valid;
    int rd;
    bit rw;
    bit mr;
  } occ_t;

  // hist[1] = instruction issued one cycle ago (in EX), hist[2] = two cycles ago (in MEM)
  occ_t hist [1:2];
  bit   last_stall;

  forward_ctrl #(.REG_ADDR_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .fwd_sel_a    (fwd_sel_a),
    .fwd_sel_b    (fwd_sel_b),
    .stall        (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s got=%0d want=%0d at %0t", tag, got, want, $time);
    end
  endtask

  // Age of the youngest in-flight writer of src (0 = none / register 0).
  function automatic int prodAge(input int src);
    if (src == 0) return 0;
    for (int a = 1; a <= 2; a++)
      if (hist[a].valid && hist[a].rw && hist[a].rd == src) return a;
    return 0;
  endfunction

  function automatic bit needsStall(input int src);
    int age;
    age = prodAge(src);
`ifdef FWD_MEM_WB_EN
    return (age == 1) && hist[1].mr;
`else
    return ((age == 1) && hist[1].mr) || (age == 2);
`endif
  endfunction

  function automatic int expSel(input int src);
    int age;
    age = prodAge(src);
`ifdef FWD_MEM_WB_EN
    return age;
`else
    return (age == 1) ? 1 : 0;
`endif
  endfunction

  task automatic clearModel();
    for (int a = 1; a <= 2; a++) hist[a] = '{valid: 0, rd: 0, rw: 0, mr: 0};
  endtask

  // Drive one cycle of ID inputs, check stall, advance the model and check selects after the edge.
  task automatic applyStimulus(input int rs, input int rt, input int rd, input bit rw,
                               input bit mr, input bit fl, input bit rs_t);
    bit   exp_stall;
    int   exp_a;
    int   exp_b;
    occ_t issued;
    id_rs        = 5'(rs);
    id_rt        = 5'(rt);
    id_rd        = 5'(rd);
    id_reg_write = rw;
    id_mem_read  = mr;
    flush        = fl;
    rst          = rs_t;
    #1;
    exp_stall = !rs_t && !fl && (needsStall(rs) || needsStall(rt));
    checkOutput("stall", {7'd0, stall}, {7'd0, exp_stall});
    if (rs_t || fl || exp_stall) begin
      exp_a = 0;
      exp_b = 0;
    end else begin
      exp_a = expSel(rs);
      exp_b = expSel(rt);
    end
    if (rs_t) begin
      clearModel();
    end else begin
      issued  = '{valid: !(fl || exp_stall), rd: rd, rw: rw, mr: mr};
      hist[2] = hist[1];
      hist[1] = issued;
    end
    last_stall = exp_stall;
    @(posedge clk);
    #1;
    checkOutput("sel_a", {6'd0, fwd_sel_a}, 8'(exp_a));
    checkOutput("sel_b", {6'd0, fwd_sel_b}, 8'(exp_b));
  endtask

  // Issue one instruction, re-presenting it while the model says it is stalled.
  task automatic issueInstr(input int rs, input int rt, input int rd, input bit rw, input bit mr);
    for (int i = 0; i < 4 && (i == 0 || last_stall); i++)
      applyStimulus(rs, rt, rd, rw, mr, 1'b0, 1'b0);
  endtask

  task automatic drain();
    issueInstr(0, 0, 0, 0, 0);
    issueInstr(0, 0, 0, 0, 0);
  endtask

  initial begin
    int  r_rs, r_rt, r_rd;
    bit  r_rw, r_mr, r_fl, r_rst;
    clearModel();
    last_stall = 0;
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(3, 3, 3, 1, 1, 0, 1);
    checkOutput("reset_stall", {7'd0, stall}, 8'd0);

    // ALU producer r3 followed directly by a consumer of r3
    issueInstr(1, 2, 3, 1, 0);
    issueInstr(3, 0, 9, 1, 0);
    checkOutput("exmem_fwd_a", {6'd0, fwd_sel_a}, 8'd1);
    drain();

    // producer r5, unrelated instruction, consumer reading r5 on rt
    issueInstr(1, 1, 5, 1, 0);
    issueInstr(1, 2, 6, 1, 0);
    issueInstr(1, 5, 8, 1, 0);
`ifdef FWD_MEM_WB_EN
    checkOutput("memwb_fwd_b", {6'd0, fwd_sel_b}, 8'd2);
`else
    checkOutput("memwb_regfile_b", {6'd0, fwd_sel_b}, 8'd0);
`endif
    drain();

    // load r7 then immediate use
    issueInstr(1, 1, 7, 1, 1);
    issueInstr(7, 1, 9, 1, 0);
`ifdef FWD_MEM_WB_EN
    checkOutput("load_use_a", {6'd0, fwd_sel_a}, 8'd2);
`else
    checkOutput("load_use_a", {6'd0, fwd_sel_a}, 8'd0);
`endif
    drain();

    // r4 in both EX and MEM: the newer one wins
    issueInstr(2, 2, 4, 1, 0);
    issueInstr(2, 2, 4, 1, 0);
    issueInstr(4, 1, 10, 1, 0);
    checkOutput("priority_a", {6'd0, fwd_sel_a}, 8'd1);
    drain();

    // writes to r0 never forward
    issueInstr(1, 1, 0, 1, 1);
    issueInstr(0, 0, 11, 1, 0);
    checkOutput("r0_sel_a", {6'd0, fwd_sel_a}, 8'd0);
    checkOutput("r0_sel_b", {6'd0, fwd_sel_b}, 8'd0);
    drain();

    // load-use coinciding with flush
    issueInstr(1, 1, 7, 1, 1);
    applyStimulus(7, 7, 9, 1, 0, 1, 0);
    checkOutput("flush_sel_a", {6'd0, fwd_sel_a}, 8'd0);
    drain();

    // reset asserted during a load-use stall
    issueInstr(1, 1, 12, 1, 1);
    applyStimulus(12, 1, 13, 1, 0, 0, 0);
    applyStimulus(12, 1, 13, 1, 0, 0, 1);
    checkOutput("rst_mid_sel_a", {6'd0, fwd_sel_a}, 8'd0);
    applyStimulus(12, 1, 13, 1, 0, 0, 0);
    checkOutput("rst_after_sel_a", {6'd0, fwd_sel_a}, 8'd0);
    drain();

    // random traffic over a small register range so hazards are frequent
    r_rs = 0; r_rt = 0; r_rd = 0; r_rw = 0; r_mr = 0;
    for (int n = 0; n < 400; n++) begin
      if (!last_stall) begin
        r_rs = int'($urandom_range(0, 7));
        r_rt = int'($urandom_range(0, 7));
        r_rd = int'($urandom_range(0, 7));
        r_rw = ($urandom_range(0, 3) != 0);
        r_mr = r_rw && ($urandom_range(0, 2) == 0);
      end
      r_fl  = ($urandom_range(0, 9) == 0);
      r_rst = ($urandom_range(0, 39) == 0);
      applyStimulus(r_rs, r_rt, r_rd, r_rw, r_mr, r_fl, r_rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/forward_ctrl.md
FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, with all state updated on the rising edge of clk.
REQ-002 Parameter REG_ADDR_W, default 5, SHALL set the register-address width.
REQ-003 Port clk, input, 1 bit: system clock.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port id_rs, input, REG_ADDR_W bits: source register A of the instruction in ID.
REQ-006 Port id_rt, input, REG_ADDR_W bits: source register B of the instruction in ID.
REQ-007 Port id_rd, input, REG_ADDR_W bits: destination register of the instruction in ID.
REQ-008 Port id_reg_write, input, 1 bit: the ID instruction writes id_rd.
REQ-009 Port id_mem_read, input, 1 bit: the ID instruction is a load.
REQ-010 Port flush, input, 1 bit: discard the ID instruction (branch taken).
REQ-011 Port fwd_sel_a, output, 2 bits, registered: select for the operand-A 3:1 mux.
REQ-012 Port fwd_sel_b, output, 2 bits, registered: select for the operand-B 3:1 mux.
REQ-013 Port stall, output, 1 bit, combinational: hold PC and IF/ID; bubble into EX.

Function
REQ-014 Select encoding SHALL be: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result; 3 SHALL never be driven.
REQ-015 Internal tracking entries ex_e, mem_e and wb_e SHALL each hold {valid, rd, reg_write, mem_read}; a bubble is valid=0.
REQ-016 Each cycle without stall or flush: ex_e <= ID fields; mem_e <= ex_e; wb_e <= mem_e.
REQ-017 On stall or flush: ex_e <= bubble; mem_e and wb_e SHALL still advance.
REQ-018 fwd_sel_a and fwd_sel_b SHALL be computed in ID and registered, so they are valid exactly during the cycle the instruction occupies EX (latency 1).
REQ-019 An operand SHALL be matched only when the entry is valid, has reg_write=1, and has rd equal to the source register with rd != 0.
REQ-020 Operand select SHALL be 1 if ex_e matches, otherwise 2 if mem_e matches, otherwise 0; the newer producer has priority.
REQ-021 stall SHALL equal: ex_e valid AND ex_e.mem_read AND ex_e matches id_rs or id_rt (per REQ-019) AND NOT flush.
REQ-022 During a stall or flush, the registered selects SHALL load 0 (bubble in EX).
REQ-023 When flush and a load-use condition coincide, flush SHALL win: stall=0 and ex_e <= bubble.
REQ-024 Register 0 SHALL never cause forwarding or a stall.
REQ-025 The cycle after a load-use stall, the same ID instruction SHALL be re-evaluated; the load is now in mem_e, giving select 2 and no second stall.

Reset
REQ-026 While rst=1: ex_e, mem_e and wb_e SHALL be bubbles; fwd_sel_a=fwd_sel_b=0; stall=0.
REQ-027 Reset asserted mid-stall SHALL clear all state at the next edge, and no stale select SHALL appear after release.

Configuration
REQ-028 Macro FWD_MEM_WB_EN defined: behaviour is as specified above.
REQ-029 Macro FWD_MEM_WB_EN undefined: select 2 SHALL never be driven; a match only on mem_e (per REQ-020) SHALL assert stall for one cycle, after which the register file supplies the value (select 0).

Structure
REQ-030 The select encodings (FWD_REGFILE, FWD_EXMEM, FWD_MEMWB) and the tracking-entry struct SHALL live in the shared lapido_pkg package.
REQ-031 One sub-module, fwd_compare, SHALL map (source register, ex_e, mem_e) to (select, load-use hit) and SHALL be instantiated twice, once for A and once for B.

Verification
REQ-032 The bench SHALL cover: add r3 (rd=3, reg_write) then next ID with rs=3 -> fwd_sel_a=1 in the following cycle, stall=0.
REQ-033 The bench SHALL cover: producer rd=5, one unrelated instruction, then a consumer with rt=5 -> fwd_sel_b=2; with FWD_MEM_WB_EN undefined -> stall=1 for one cycle, then fwd_sel_b=0.
REQ-034 The bench SHALL cover: load rd=7 then consumer rs=7 -> stall=1 for exactly one cycle, then fwd_sel_a=2.
REQ-035 The bench SHALL cover: producers rd=4 in both ex_e and mem_e and a consumer with rs=4 -> fwd_sel_a=1 (priority).
REQ-036 The bench SHALL cover: rd=0 with reg_write=1 and a consumer with rs=0 -> select 0, stall=0.
REQ-037 The bench SHALL cover: a load-use condition with flush=1 in the same cycle -> stall=0 and next selects=0; rst asserted during a stall -> all outputs 0 on the next edge.
